// File: rtl/arb2_rr.sv
`default_nettype none
// ============================================================================
// arb2_rr : two-requester round-robin arbiter with lock bursts and a
//           registered, back-pressurable output stage.   Rev 1.0
// ============================================================================
module arb2_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req0_lock,
  input  logic             req1_lock,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel,
  output logic             locked
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e           state_q;
  logic             last_q;
  logic             out_valid_q;
  logic             sel_q;
  logic [WIDTH-1:0] out_data_q;

  logic load;
  logic grant;
  logic grant_any;
  logic xfer0;
  logic xfer1;

  assign load = !out_valid_q || out_ready;

  always_comb begin
    grant     = 1'b0;
    grant_any = 1'b0;
    unique case (state_q)
      LOCK0: begin
        grant     = 1'b0;
        grant_any = 1'b1;
      end
      LOCK1: begin
        grant     = 1'b1;
        grant_any = 1'b1;
      end
      default: begin
        if (req0_valid && req1_valid) begin
          grant     = ~last_q;
          grant_any = 1'b1;
        end else if (req1_valid) begin
          grant     = 1'b1;
          grant_any = 1'b1;
        end else if (req0_valid) begin
          grant     = 1'b0;
          grant_any = 1'b1;
        end
      end
    endcase
  end

  // Gating with reset_n keeps both readys low for the whole reset window.
  assign req0_ready = reset_n && load && grant_any && !grant && req0_valid;
  assign req1_ready = reset_n && load && grant_any &&  grant && req1_valid;
  assign xfer0      = req0_ready;
  assign xfer1      = req1_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= 1'b0;
    end else begin
      if (xfer0 || xfer1) begin
        out_valid_q <= 1'b1;
        out_data_q  <= xfer1 ? req1_data : req0_data;
        sel_q       <= xfer1;
        last_q      <= xfer1;
      end else if (load) begin
        out_valid_q <= 1'b0;
      end

      unique case (state_q)
        ARB: begin
          if (xfer0 && req0_lock)      state_q <= LOCK0;
          else if (xfer1 && req1_lock) state_q <= LOCK1;
        end
        LOCK0: begin
          if ((xfer0 && !req0_lock) || (load && !req0_valid)) state_q <= ARB;
        end
        LOCK1: begin
          if ((xfer1 && !req1_lock) || (load && !req1_valid)) state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign locked    = (state_q == LOCK0) || (state_q == LOCK1);

endmodule
`default_nettype wire

// File: tb/tb_arb2_rr.sv
`default_nettype none
// ============================================================================
// tb_arb2_rr : directed scenarios plus a randomized run against a
//              transaction-level owner/last model.   Rev 1.0
// ============================================================================
module tb_arb2_rr;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req1_valid, req0_lock, req1_lock;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       out_valid, out_ready, sel, locked;
  logic [7:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner = -1 when arbitrating freely, else the requester holding a lock.
  int         m_owner;
  bit         m_last, m_ov, m_sel;
  logic [7:0] m_od;
  bit         exp_r0, exp_r1;
  logic       act_r0, act_r1;

  arb2_rr #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_lock(req0_lock), .req1_lock(req1_lock),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel), .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_owner = -1; m_last = 1'b1; m_ov = 1'b0; m_od = 8'h00; m_sel = 1'b0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input bit v0, input logic [7:0] d0, input bit l0,
                       input bit v1, input logic [7:0] d1, input bit l1,
                       input bit ordy);
    int  g;
    bit  ld, lk, n;
    req0_valid = v0; req0_data = d0; req0_lock = l0;
    req1_valid = v1; req1_data = d1; req1_lock = l1;
    out_ready  = ordy;
    #1;
    act_r0 = req0_ready;
    act_r1 = req1_ready;
    ld = !m_ov || ordy;
    if (m_owner >= 0)   g = m_owner;
    else if (v0 && v1)  g = m_last ? 0 : 1;
    else if (v1)        g = 1;
    else if (v0)        g = 0;
    else                g = -1;
    exp_r0 = ld && (g == 0) && v0;
    exp_r1 = ld && (g == 1) && v1;
    @(posedge clk);
    #1;
    if (exp_r0 || exp_r1) begin
      n      = exp_r1;
      lk     = n ? l1 : l0;
      m_ov   = 1'b1;
      m_od   = n ? d1 : d0;
      m_sel  = n;
      m_last = n;
      if (m_owner < 0 || m_owner == int'(n)) m_owner = lk ? int'(n) : -1;
    end else if (ld) begin
      m_ov = 1'b0;
      if (m_owner == 0 && !v0) m_owner = -1;
      if (m_owner == 1 && !v1) m_owner = -1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0_valid = 1; req1_valid = 1; req0_data = 8'hAA; req1_data = 8'hBB;
    req0_lock = 1; req1_lock = 1; out_ready = 1;
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_cmp++; if (sel !== 1'b0) begin n_bad++; $display("FAIL reset_sel: got %b want 0", sel); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_readys: got %b%b want 00", req0_ready, req1_ready); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_tie();
    logic [7:0] want;
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h11, 0, 1, 8'h22, 0, 1);
      want = (i % 2 == 1) ? 8'h22 : 8'h11;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL tie_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== want) begin n_bad++; $display("FAIL tie_data[%0d]: got %h want %h", i, out_data, want); end
      n_cmp++; if (sel !== 1'(i % 2)) begin n_bad++; $display("FAIL tie_sel[%0d]: got %b want %0d", i, sel, i % 2); end
    end
  endtask

  task automatic test_single();
    logic [7:0] want;
    idle();
    for (int i = 0; i < 4; i++) begin
      want = 8'hA0 + 8'(i);
      drive(0, 8'h00, 0, 1, want, 0, 1);
      n_cmp++; if ({act_r0, act_r1} !== 2'b01) begin n_bad++; $display("FAIL single_readys[%0d]: got %b%b want 01", i, act_r0, act_r1); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== want) begin n_bad++; $display("FAIL single_data[%0d]: got v=%b %h want v=1 %h", i, out_valid, out_data, want); end
      n_cmp++; if (sel !== 1'b1) begin n_bad++; $display("FAIL single_sel[%0d]: got %b want 1", i, sel); end
    end
  endtask

  task automatic test_backpressure();
    idle();
    drive(1, 8'h55, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h66, 0, 1, 8'h22, 0, 0);
      n_cmp++; if ({act_r0, act_r1} !== 2'b00) begin n_bad++; $display("FAIL bp_readys[%0d]: got %b%b want 00", i, act_r0, act_r1); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 55", i, out_valid, out_data); end
    end
    drive(1, 8'h66, 0, 1, 8'h22, 0, 1);
    n_cmp++; if (act_r1 !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready1: got %b want 1", act_r1); end
    n_cmp++; if (out_data !== 8'h22 || sel !== 1'b1) begin n_bad++; $display("FAIL bp_release_word: got %h sel=%b want 22 sel=1", out_data, sel); end
  endtask

  task automatic test_lock_burst();
    logic [7:0] wd [3];
    bit         wl [3];
    wd = '{8'h01, 8'h02, 8'h03};
    wl = '{1'b1, 1'b1, 1'b0};
    idle();
    for (int i = 0; i < 3; i++) begin
      drive(1, wd[i], wl[i], i > 0, 8'h77, i == 1, 1);
      n_cmp++; if ({act_r0, act_r1} !== 2'b10) begin n_bad++; $display("FAIL lock_readys[%0d]: got %b%b want 10", i, act_r0, act_r1); end
      n_cmp++; if (out_data !== wd[i] || out_valid !== 1'b1) begin n_bad++; $display("FAIL lock_word[%0d]: got v=%b %h want v=1 %h", i, out_valid, out_data, wd[i]); end
      n_cmp++; if (locked !== wl[i]) begin n_bad++; $display("FAIL lock_locked[%0d]: got %b want %b", i, locked, wl[i]); end
    end
    drive(1, 8'h04, 0, 1, 8'h77, 0, 1);
    n_cmp++; if (out_data !== 8'h77 || sel !== 1'b1) begin n_bad++; $display("FAIL lock_after: got %h sel=%b want 77 sel=1", out_data, sel); end
  endtask

  task automatic test_lock_drop();
    idle();
    drive(0, 8'h00, 0, 1, 8'h31, 1, 1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL drop_enter: got locked=%b want 1", locked); end
    drive(1, 8'h40, 0, 0, 8'h00, 0, 1);
    n_cmp++; if (act_r0 !== 1'b0) begin n_bad++; $display("FAIL drop_ready0_in_lock: got %b want 0", act_r0); end
    n_cmp++; if (locked !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL drop_exit: got locked=%b v=%b want 0 0", locked, out_valid); end
    drive(1, 8'h40, 0, 0, 8'h00, 0, 1);
    n_cmp++; if (act_r0 !== 1'b1 || out_data !== 8'h40 || sel !== 1'b0) begin n_bad++; $display("FAIL drop_grant0: got r0=%b %h sel=%b want 1 40 0", act_r0, out_data, sel); end
  endtask

  task automatic test_reset_mid_lock();
    idle();
    drive(1, 8'h99, 1, 0, 8'h00, 0, 0);
    n_cmp++; if (locked !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL rml_setup: got locked=%b v=%b want 1 1", locked, out_valid); end
    req1_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || locked !== 1'b0 || sel !== 1'b0 || out_data !== 8'h00) begin n_bad++; $display("FAIL rml_async: got v=%b locked=%b sel=%b %h want 0 0 0 00", out_valid, locked, sel, out_data); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL rml_readys: got %b%b want 00", req0_ready, req1_ready); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 8'h11, 0, 1, 8'h22, 0, 1);
    n_cmp++; if (act_r0 !== 1'b1 || out_data !== 8'h11 || sel !== 1'b0) begin n_bad++; $display("FAIL rml_first_tie: got r0=%b %h sel=%b want 1 11 0", act_r0, out_data, sel); end
  endtask

  task automatic test_random();
    bit v0, v1, l0, l1, ordy;
    logic [7:0] d0, d1;
    for (int i = 0; i < 500; i++) begin
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      l0 = 1'($urandom_range(0, 1)); l1 = 1'($urandom_range(0, 1));
      d0 = 8'($urandom); d1 = 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      drive(v0, d0, l0, v1, d1, l1, ordy);
      n_cmp++; if ({act_r0, act_r1} !== {exp_r0, exp_r1}) begin n_bad++; $display("FAIL rnd_readys[%0d]: got %b%b want %b%b", i, act_r0, act_r1, exp_r0, exp_r1); end
      n_cmp++; if (out_valid !== m_ov || out_data !== m_od || sel !== m_sel) begin n_bad++; $display("FAIL rnd_out[%0d]: got v=%b %h sel=%b want v=%b %h sel=%b", i, out_valid, out_data, sel, m_ov, m_od, m_sel); end
      n_cmp++; if (locked !== (m_owner >= 0)) begin n_bad++; $display("FAIL rnd_locked[%0d]: got %b want %b", i, locked, m_owner >= 0); end
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_backpressure();
    test_lock_burst();
    test_lock_drop();
    test_reset_mid_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb2_rr.md
ARB2_RR -- requirements
Module: arb2_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the width of every data port in bits.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the ports req0_valid and req1_valid, input, 1 bit each: requester has a word to transfer.
REQ-005 The block SHALL have the ports req0_data and req1_data, input, WIDTH bits each: requester payload.
REQ-006 The block SHALL have the ports req0_lock and req1_lock, input, 1 bit each: requester asks to keep the grant after this transfer.
REQ-007 The block SHALL have the ports req0_ready and req1_ready, output, 1 bit each: requester word accepted this cycle.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: out_data holds a word.
REQ-009 The block SHALL have the port out_data, output, WIDTH bits: registered selected payload.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: consumer takes the word this cycle.
REQ-011 The block SHALL have the port sel, output, 1 bit: source of the word in out_data (0 = req0, 1 = req1).
REQ-012 The block SHALL have the port locked, output, 1 bit: the FSM is in LOCK0 or LOCK1.

Function
REQ-013 The block SHALL define load = !out_valid || out_ready; the output register accepts a new word only when load = 1.
REQ-014 The block SHALL drive reqN_ready = load && (grant == N) && reqN_valid, combinationally; at most one ready SHALL be high in any cycle.
REQ-015 A transfer from requester N SHALL occur when reqN_valid && reqN_ready.
REQ-016 On a transfer, the block SHALL set out_data <= reqN_data, out_valid <= 1, sel <= N and last <= N at the next edge; latency from accept to out_valid SHALL be 1 cycle.
REQ-017 When load = 1 and there is no transfer, the block SHALL set out_valid <= 0; out_data and sel SHALL hold their values.
REQ-018 The FSM SHALL have exactly three states: ARB, LOCK0 and LOCK1.
REQ-019 In ARB, the grant SHALL be chosen as follows:
- Only one requester valid: grant that requester.
- Both valid: grant = ~last (round-robin).
- Neither valid: no grant.
REQ-020 In ARB, a transfer from requester N with reqN_lock = 1 SHALL move the FSM to LOCKN; otherwise the FSM SHALL stay in ARB.
REQ-021 In LOCKN, grant SHALL be N only, and the other requester's ready SHALL be 0 even if it is valid.
REQ-022 In LOCKN, the FSM SHALL return to ARB on either of these events:
- A transfer from N with reqN_lock = 0.
- A cycle where load = 1 and reqN_valid = 0.
Otherwise the FSM SHALL stay in LOCKN.
REQ-023 In LOCKN, the block SHALL ignore a change of the other requester's lock input.
REQ-024 Back-pressure: while out_valid = 1 and out_ready = 0, both readys SHALL be 0 and the FSM state, last, out_data and sel SHALL hold.
REQ-025 Simultaneous drain and fill: out_ready = 1 with a transfer in the same cycle SHALL give back-to-back words with no bubble (full throughput, 1 word per cycle).
REQ-026 The block SHALL drive locked = 1 exactly in LOCK0 and LOCK1.

Reset
REQ-027 reset_n = 0 SHALL immediately (asynchronously) set:
- out_valid = 0, out_data = 0, sel = 0, locked = 0;
- FSM = ARB, last = 1, so req0 wins the first tie.
REQ-028 While reset_n = 0, both readys SHALL be 0.
REQ-029 Reset asserted mid-lock or mid-backpressure SHALL discard the held word with no transfer completed.
REQ-030 After reset_n deasserts, the first transfer SHALL be possible on the first rising edge.

Verification
REQ-031 Reset then tie: both valid, data0=0x11, data1=0x22, out_ready=1 -> accepted in order 0x11, 0x22, 0x11, ... with sel alternating 0, 1, 0, and a word every cycle.
REQ-032 Single requester: only req1 valid, streaming 0xA0..0xA3, out_ready=1 -> 4 consecutive words 0xA0..0xA3 with sel=1 and req0_ready=0 throughout.
REQ-033 Back-pressure: out_valid=1 with 0x55 and out_ready=0 for 3 cycles, both valid -> readys=0 and out_data=0x55 stable; on release, the next word follows round-robin order.
REQ-034 Lock burst: req0 sends 0x01, 0x02, 0x03 with lock=1, 1, 0 while req1 is valid -> the three words arrive contiguously with locked=1 for 2 cycles, then req1's word follows.
REQ-035 Lock drop: in LOCK1, req1_valid falls with load=1 -> FSM returns to ARB the next cycle and a pending req0 is granted.
REQ-036 Reset mid-lock: reset_n pulsed low while in LOCK0 with out_valid=1 -> out_valid=0, locked=0 and sel=0 immediately; the next tie grants req0.
